// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the bus host arbiter
package bus_arb_pkg;
  typedef enum logic {ArbIdle, ArbWait} arb_state_e;
  localparam int unsigned BeWidth = 4;
endpackage

// File: rtl/bus_arb_rr_pick.sv
// bus_arb_rr_pick: rotate-priority picker, first set request at or after ptr_i modulo N
module bus_arb_rr_pick #(
  parameter int unsigned N = 3,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);
  logic [PW-1:0] j;
  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    j = '0;
    for (int i = 0; i < int'(N); i++) begin
      j = PW'((int'(ptr_i) + i) % int'(N));
      if (!valid_o && req_i[j]) begin
        idx_o = j;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter: round-robin sharing of one device bus port among NrHosts hosts,
// single outstanding transaction, response routing and device timeout.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts = 3,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                                  clk_sys_i,
  input  logic                                  rst_sys_ni,
  input  logic [NrHosts-1:0]                    host_req_i,
  output logic [NrHosts-1:0]                    host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i,
  input  logic [NrHosts-1:0]                    host_we_i,
  input  logic [NrHosts-1:0][BeWidth-1:0]       host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
  output logic [NrHosts-1:0]                    host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
  output logic [NrHosts-1:0]                    host_err_o,
  output logic                                  dev_req_o,
  output logic [AddressWidth-1:0]               dev_addr_o,
  output logic                                  dev_we_o,
  output logic [BeWidth-1:0]                    dev_be_o,
  output logic [DataWidth-1:0]                  dev_wdata_o,
  input  logic                                  dev_rvalid_i,
  input  logic [DataWidth-1:0]                  dev_rdata_i,
  input  logic                                  dev_err_i,
  output logic                                  busy_o,
  output logic                                  timeout_o
);
  localparam int unsigned PtrW = $clog2(NrHosts);
  localparam int unsigned CntW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

  arb_state_e state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, winner;
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic win_valid, grant, rsp, tmo;

  bus_arb_rr_pick #(.N(NrHosts), .PW(PtrW)) u_pick (
    .req_i  (host_req_i),
    .ptr_i  (rr_ptr_q),
    .idx_o  (winner),
    .valid_o(win_valid)
  );

  // Grants are qualified by rst_sys_ni so requests cannot leak a grant while reset is held.
  always_comb begin
    rsp = state_q == ArbWait && dev_rvalid_i;
    tmo = TimeoutCycles > 0 && state_q == ArbWait && !dev_rvalid_i && tmo_cnt_q == CntLast;
    grant = rst_sys_ni && win_valid && (state_q == ArbIdle || dev_rvalid_i);
    state_d = grant ? ArbWait : (rsp || tmo) ? ArbIdle : state_q;
    owner_d = grant ? winner : owner_q;
    rr_ptr_d = !grant ? rr_ptr_q : (winner == PtrW'(NrHosts - 1)) ? '0 : winner + 1'b1;
    tmo_cnt_d = grant ? '0 :
                (state_q == ArbWait && !dev_rvalid_i && tmo_cnt_q != CntMax) ? tmo_cnt_q + 1'b1 :
                tmo_cnt_q;
    host_gnt_o = grant ? NrHosts'(1) << winner : '0;
    host_rvalid_o = (rsp || tmo) ? NrHosts'(1) << owner_q : '0;
    host_rdata_o = '0;
    host_err_o = '0;
    if (rsp) host_rdata_o[owner_q] = dev_rdata_i;
    if (rsp || tmo) host_err_o[owner_q] = rsp ? dev_err_i : 1'b1;
    dev_req_o = grant;
    dev_addr_o = grant ? host_addr_i[winner] : '0;
    dev_we_o = grant ? host_we_i[winner] : 1'b0;
    dev_be_o = grant ? host_be_i[winner] : '0;
    dev_wdata_o = grant ? host_wdata_i[winner] : '0;
    busy_o = state_q == ArbWait;
    timeout_o = tmo;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= ArbIdle;
      rr_ptr_q <= '0;
      owner_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb_bus_host_arbiter: randomized bench checking the arbiter against a transaction-level model
module tb_bus_host_arbiter;
  localparam int N = 3, T = 4, DW = 32, AW = 32;
  logic clk_sys_i = 1'b0, rst_sys_ni = 1'b0;
  logic [N-1:0] host_req_i, host_gnt_o, host_we_i, host_rvalid_o, host_err_o;
  logic [N-1:0][AW-1:0] host_addr_i;
  logic [N-1:0][3:0] host_be_i;
  logic [N-1:0][DW-1:0] host_wdata_i, host_rdata_o;
  logic dev_req_o, dev_we_o, dev_rvalid_i, dev_err_i, busy_o, timeout_o;
  logic [AW-1:0] dev_addr_o;
  logic [3:0] dev_be_o;
  logic [DW-1:0] dev_wdata_o, dev_rdata_i;

  always #5 clk_sys_i = ~clk_sys_i;

  bus_host_arbiter #(.NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(T)) dut (
    .clk_sys_i(clk_sys_i), .rst_sys_ni(rst_sys_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o),
    .dev_wdata_o(dev_wdata_o), .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
    .dev_err_i(dev_err_i), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int errors = 0, checks = 0;
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each host holds a pending request; a grant opens one transaction whose
  // device answer is scheduled at a chosen latency (0 = never, forcing a timeout).
  int t = 0, owner = 0, rr = 0, gnt_t = 0, rsp_t = -1;
  bit busy = 0, rsp_err = 0;
  logic [DW-1:0] rsp_data = '0;
  bit pend[N];
  logic [AW-1:0] a[N];
  logic w[N];
  logic [3:0] b[N];
  logic [DW-1:0] d[N];
  int req_pct = 0, lat_fix = 1, err_pct = 12, stray_pct = 15;
  bit rd_fix_en = 0;
  logic [DW-1:0] rd_fix = '0;

  task automatic new_req(input int i);
    pend[i] = 1;
    a[i] = $urandom;
    w[i] = 1'($urandom_range(1));
    b[i] = 4'($urandom);
    d[i] = $urandom;
  endtask

  task automatic drive_hosts();
    for (int i = 0; i < N; i++) begin
      host_req_i[i] = pend[i];
      host_addr_i[i] = a[i];
      host_we_i[i] = w[i];
      host_be_i[i] = b[i];
      host_wdata_i[i] = d[i];
    end
  endtask

  task automatic step();
    int win, l;
    bit rv, rsp, tmo;
    logic [N-1:0] e_gnt, e_rv, e_err;
    logic [N*DW-1:0] e_rd;
    logic [AW-1:0] e_addr;
    logic [3:0] e_be;
    logic [DW-1:0] e_wd;
    logic e_we;
    @(posedge clk_sys_i);
    #1;
    t++;
    for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(99) < req_pct) new_req(i);
    drive_hosts();
    rv = busy && t == rsp_t;
    dev_rvalid_i = rv || (!busy && $urandom_range(99) < stray_pct);
    dev_rdata_i = rv ? rsp_data : $urandom;
    dev_err_i = rv ? rsp_err : 1'($urandom_range(1));
    rsp = busy && rv;
    tmo = busy && !rv && (t - gnt_t == T);
    win = -1;
    if (!busy || rv)
      for (int k = 0; k < N; k++) if (win < 0 && pend[(rr + k) % N]) win = (rr + k) % N;
    e_gnt = '0; e_rv = '0; e_err = '0; e_rd = '0;
    e_addr = '0; e_be = '0; e_wd = '0; e_we = 1'b0;
    if (win >= 0) begin
      e_gnt = N'(1) << win;
      e_addr = a[win]; e_we = w[win]; e_be = b[win]; e_wd = d[win];
    end
    if (rsp || tmo) begin
      e_rv = N'(1) << owner;
      e_err = (rsp ? N'(rsp_err) : N'(1)) << owner;
      if (rsp) e_rd = (N*DW)'(rsp_data) << (owner * DW);
    end
    @(negedge clk_sys_i);
    check_eq("gnt", host_gnt_o, e_gnt);
    check_eq("dev_req", dev_req_o, win >= 0);
    check_eq("dev_addr", dev_addr_o, e_addr);
    check_eq("dev_we", dev_we_o, e_we);
    check_eq("dev_be", dev_be_o, e_be);
    check_eq("dev_wdata", dev_wdata_o, e_wd);
    check_eq("rvalid", host_rvalid_o, e_rv);
    check_eq("rdata", host_rdata_o, e_rd);
    check_eq("err", host_err_o, e_err);
    check_eq("busy", busy_o, busy);
    check_eq("timeout", timeout_o, tmo);
    if (win >= 0) begin
      busy = 1; owner = win; rr = (win + 1) % N; gnt_t = t; pend[win] = 0;
      l = lat_fix >= 0 ? lat_fix : ($urandom_range(9) == 0 ? 0 : $urandom_range(9) < 6 ? 1 : int'($urandom_range(2, 4)));
      rsp_t = l == 0 ? -1 : t + l;
      rsp_data = rd_fix_en ? rd_fix : $urandom;
      rsp_err = $urandom_range(99) < err_pct;
    end else if (rsp || tmo) busy = 0;
  endtask

  task automatic do_reset();
    rst_sys_ni = 1'b0;
    for (int i = 0; i < N; i++) if (!pend[i]) new_req(i);
    drive_hosts();
    dev_rvalid_i = 1'b1;
    dev_rdata_i = $urandom;
    #1;
    check_eq("rst_gnt", host_gnt_o, '0);
    check_eq("rst_rvalid", host_rvalid_o, '0);
    check_eq("rst_err", host_err_o, '0);
    check_eq("rst_rdata", host_rdata_o, '0);
    check_eq("rst_dev_req", dev_req_o, '0);
    check_eq("rst_dev_addr", dev_addr_o, '0);
    check_eq("rst_busy", busy_o, '0);
    check_eq("rst_timeout", timeout_o, '0);
    @(posedge clk_sys_i);
    #1;
    host_req_i = '0;
    dev_rvalid_i = 1'b0;
    rst_sys_ni = 1'b1;
    busy = 0; rr = 0; owner = 0; rsp_t = -1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      new_req(i);
      pend[i] = 0;
    end
    dev_rvalid_i = 1'b0; dev_rdata_i = '0; dev_err_i = 1'b0;
    drive_hosts();
    #2;
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    // single host read with a one-cycle device
    rd_fix_en = 1; rd_fix = 32'hA5; err_pct = 0;
    new_req(1); a[1] = 32'h8000_0000; w[1] = 1'b0;
    step();
    check_eq("t1_gnt", host_gnt_o, 3'b010);
    step();
    check_eq("t1_rvalid", host_rvalid_o, 3'b010);
    check_eq("t1_rdata", host_rdata_o[1], 32'hA5);
    // rr_ptr now 2, hosts 0 and 1 request: host 0 wins
    rd_fix_en = 0;
    new_req(0); new_req(1);
    step();
    check_eq("t3_gnt", host_gnt_o, 3'b001);
    repeat (2) step();
    // all hosts requesting continuously, then device errors
    req_pct = 100;
    repeat (12) step();
    err_pct = 100;
    repeat (6) step();
    err_pct = 12; req_pct = 0;
    repeat (3) step();
    // silent device on host 2
    lat_fix = 0;
    new_req(2);
    repeat (5) step();
    check_eq("t4_tmo", timeout_o, 1'b1);
    check_eq("t4_err", host_err_o, 3'b100);
    new_req(0);
    step();
    check_eq("t4_regnt", host_gnt_o, 3'b001);
    // reset while waiting, then all hosts request
    repeat (2) step();
    do_reset();
    step();
    check_eq("t6_gnt", host_gnt_o, 3'b001);
    // random traffic
    lat_fix = -1; req_pct = 40;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) do_reset();
      if (n % 400 == 0) req_pct = int'($urandom_range(10, 100));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
